boton_antirrebote: RTL and testbench

//  Input conditioner between the board push-buttons/tilt switch and FSM_Central.
//  Two-flop synchronises, debounces and edge-detects each raw input.

---
 rtl/boton_antirrebote.sv | 95 +++++++++
 tb/tb_boton_antirrebote.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/boton_antirrebote.sv
// Input conditioner: synchronises, debounces and edge-detects the push-buttons and tilt switch,
// and raises a one-shot long-press pulse on the test button.
module boton_antirrebote #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 250_000_000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_raw,
  input  logic       giro_raw,
  output logic [4:0] btn_pulse,
  output logic [4:0] btn_level,
  output logic       giro_level,
  output logic       test_long
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HC_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HC_SAT   = HW'(HOLD_CYCLES);

  logic [5:0] raw_all;
  logic [5:0] stable_all;
  logic [4:0] pulse_all;

  assign raw_all = {giro_raw, btn_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_ch
      logic          s1_reg;
      logic          s2_reg;
      logic          stable_reg;
      logic [CW-1:0] cnt_reg;
      logic          accept;

      // A change is accepted only after an unbroken run of differing samples.
      assign accept = (s2_reg != stable_reg) && (cnt_reg == CNT_LAST);

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_reg     <= ACTIVE_LOW;
          s2_reg     <= 1'b0;
          stable_reg <= 1'b0;
          cnt_reg    <= '0;
        end else begin
          s1_reg <= raw_all[gi];
          s2_reg <= s1_reg ^ ACTIVE_LOW;
          if (s2_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (accept) begin
            stable_reg <= s2_reg;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign stable_all[gi] = stable_reg;

      if (gi < 5) begin : g_pulse
        logic pulse_reg;
        // Registered alongside the level so the pulse lines up with the level's rising edge.
        always_ff @(posedge clk) begin
          if (rst) pulse_reg <= 1'b0;
          else     pulse_reg <= accept & s2_reg;
        end
        assign pulse_all[gi] = pulse_reg;
      end
    end
  endgenerate

  logic [HW-1:0] hc_reg;
  logic          test_long_reg;

  // Hold counter saturates one past the trigger value so the pulse cannot repeat.
  always_ff @(posedge clk) begin
    if (rst || !stable_all[4]) begin
      hc_reg        <= '0;
      test_long_reg <= 1'b0;
    end else begin
      test_long_reg <= (hc_reg == HC_LAST);
      if (hc_reg != HC_SAT) hc_reg <= hc_reg + 1'b1;
    end
  end

  assign btn_pulse  = pulse_all;
  assign btn_level  = stable_all[4:0];
  assign giro_level = stable_all[5];
  assign test_long  = test_long_reg;

endmodule

// File: tb/tb_boton_antirrebote.sv
// Directed bench for boton_antirrebote with DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, active-low pins.
module tb_boton_antirrebote;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn_raw;
  logic       giro_raw;
  logic [4:0] btn_pulse;
  logic [4:0] btn_level;
  logic       giro_level;
  logic       test_long;

  int checks = 0;
  int errors = 0;

  boton_antirrebote #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (20),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .giro_raw  (giro_raw),
    .btn_pulse (btn_pulse),
    .btn_level (btn_level),
    .giro_level(giro_level),
    .test_long (test_long)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pins driven just after an edge are seen pressed-and-debounced after the 6th following edge.
  task automatic window(input string tag, input int n, input int pulse_at,
                        input logic [4:0] pmask, input int tl_at);
    for (int t = 1; t <= n; t++) begin
      tick();
      check($sformatf("%s_pulse_t%0d", tag, t), 32'(btn_pulse), (t == pulse_at) ? 32'(pmask) : 32'd0);
      check($sformatf("%s_long_t%0d", tag, t), 32'(test_long), (t == tl_at) ? 32'd1 : 32'd0);
    end
    $display("scenario %s done: %0d cycles, checks=%0d errors=%0d", tag, n, checks, errors);
  endtask

  initial begin
    rst      = 1'b1;
    btn_raw  = 5'b11111;
    giro_raw = 1'b1;
    repeat (3) tick();
    check("rst_pulse", 32'(btn_pulse), 32'd0);
    check("rst_level", 32'(btn_level), 32'd0);
    check("rst_giro",  32'(giro_level), 32'd0);
    check("rst_long",  32'(test_long), 32'd0);
    rst = 1'b0;
    window("idle", 3, 0, 5'b0, 0);

    // Clean press and release of feed
    btn_raw[2] = 1'b0;
    window("press", 8, 6, 5'b00100, 0);
    check("press_level", 32'(btn_level), 32'h04);
    btn_raw[2] = 1'b1;
    window("release", 8, 0, 5'b0, 0);
    check("release_level", 32'(btn_level), 32'h00);

    // Bouncing sleep: short runs never reach the threshold
    for (int r = 0; r < 4; r++) begin
      btn_raw[0] = (r % 2 == 0) ? 1'b0 : 1'b1;
      window("bounce", 2, 0, 5'b0, 0);
    end
    btn_raw[0] = 1'b0;
    window("settle", 8, 6, 5'b00001, 0);
    check("settle_level", 32'(btn_level), 32'h01);
    btn_raw[0] = 1'b1;
    window("settle_rel", 8, 0, 5'b0, 0);

    // Glitch of 3 cycles on play, one short of acceptance
    btn_raw[3] = 1'b0;
    window("glitch", 3, 0, 5'b0, 0);
    btn_raw[3] = 1'b1;
    window("glitch_after", 8, 0, 5'b0, 0);
    check("glitch_level", 32'(btn_level), 32'h00);

    // Long press of test
    btn_raw[4] = 1'b0;
    window("long", 30, 6, 5'b10000, 26);
    check("long_level", 32'(btn_level), 32'h10);
    btn_raw[4] = 1'b1;
    window("long_rel", 10, 0, 5'b0, 0);
    check("long_rel_level", 32'(btn_level), 32'h00);

    // Simultaneous sleep + feed
    btn_raw = 5'b11010;
    window("simul", 8, 6, 5'b00101, 0);
    check("simul_level", 32'(btn_level), 32'h05);
    btn_raw = 5'b11111;
    window("simul_rel", 8, 0, 5'b0, 0);
    check("simul_rel_level", 32'(btn_level), 32'h00);

    // Tilt switch level
    giro_raw = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      check($sformatf("giro_t%0d", t), 32'(giro_level), (t >= 6) ? 32'd1 : 32'd0);
    end
    giro_raw = 1'b1;
    window("giro_rel", 8, 0, 5'b0, 0);
    check("giro_rel_level", 32'(giro_level), 32'd0);

    // Reset mid-debounce, then mid-hold, with test held throughout
    btn_raw[4] = 1'b0;
    window("pre_rst", 3, 0, 5'b0, 0);
    rst = 1'b1;
    tick();
    check("rst1_pulse", 32'(btn_pulse), 32'd0);
    check("rst1_level", 32'(btn_level), 32'd0);
    check("rst1_long",  32'(test_long), 32'd0);
    rst = 1'b0;
    window("after_rst1", 16, 6, 5'b10000, 0);
    check("after_rst1_level", 32'(btn_level), 32'h10);
    rst = 1'b1;
    tick();
    check("rst2_pulse", 32'(btn_pulse), 32'd0);
    check("rst2_level", 32'(btn_level), 32'd0);
    check("rst2_long",  32'(test_long), 32'd0);
    rst = 1'b0;
    window("after_rst2", 28, 6, 5'b10000, 26);
    btn_raw[4] = 1'b1;
    window("final_rel", 8, 0, 5'b0, 0);
    check("final_level", 32'(btn_level), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
